imul_pipe: RTL and testbench



---
 rtl/imul_pipe_if.sv | 25 ++
 rtl/imul_pipe.sv | 116 +++++++++++
 tb/tb_imul_pipe.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imul_pipe_if.sv
// imul_pipe_if: issue/result bundle for the pipelined integer multiplier
interface imul_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 9
);
  logic             clkEn;
  logic             flush;
  logic             in_en;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] C;
  logic             out_vld;
  logic [TAG_W-1:0] out_tag;
  logic [WIDTH-1:0] Res;
  logic [5:0]       flg;
  modport master (
    output clkEn, flush, in_en, in_op, in_tag, R, C,
    input  out_vld, out_tag, Res, flg
  );
  modport slave (
    input  clkEn, flush, in_en, in_op, in_tag, R, C,
    output out_vld, out_tag, Res, flg
  );
endinterface

// File: rtl/imul_pipe.sv
// imul_pipe: STAGES-deep WIDTH x WIDTH multiplier with tag, flush and {CF,OF,AF,SF,ZF,PF} flags
// IMUL_PIPE_SWP_EN builds the byte-swap ops 6/7; otherwise they return zero
module imul_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 3,
  parameter int TAG_W  = 9
) (
  input logic        clk,
  input logic        rst,
  imul_pipe_if.slave io
);
  localparam int W = WIDTH;
  localparam int H = WIDTH / 2;
  localparam int D = STAGES - 1;
  logic [H-1:0] al, ah, bl, bh;
  logic sgn;
  assign al = io.R[H-1:0];
  assign ah = io.R[W-1:H];
  assign bl = io.C[H-1:0];
  assign bh = io.C[W-1:H];
  assign sgn = ~io.in_op[2] & io.in_op[1];
  logic v0;
  logic [2:0] op0;
  logic [TAG_W-1:0] tag0;
  logic [W-1:0] pp00, pp01, pp10, pp11, corr, swp;
  logic [H-1:0] hcorr;
  // signed products = unsigned product minus the operand-sign corrections in the upper half
  always_ff @(posedge clk)
    if (rst) begin
      v0 <= 1'b0;
      op0 <= '0;
      tag0 <= '0;
      pp00 <= '0;
      pp01 <= '0;
      pp10 <= '0;
      pp11 <= '0;
      corr <= '0;
      hcorr <= '0;
    end else if (io.clkEn) begin
      v0 <= io.in_en & ~io.flush;
      op0 <= io.in_op;
      tag0 <= io.in_tag;
      pp00 <= W'(al) * W'(bl);
      pp01 <= W'(al) * W'(bh);
      pp10 <= W'(ah) * W'(bl);
      pp11 <= W'(ah) * W'(bh);
      corr <= (sgn & io.R[W-1] ? io.C : '0) + (sgn & io.C[W-1] ? io.R : '0);
      hcorr <= (io.R[H-1] ? bl : '0) + (io.C[H-1] ? al : '0);
    end
`ifdef IMUL_PIPE_SWP_EN
  function automatic logic [W-1:0] brev(input logic [W-1:0] x, input int n);
    brev = '0;
    for (int i = 0; i < n; i++) brev[8*i +: 8] = x[8*(n-1-i) +: 8];
  endfunction
  always_ff @(posedge clk)
    if (rst) swp <= '0;
    else if (io.clkEn) swp <= io.in_op[0] ? brev(io.R, W / 8) : brev({{H{1'b0}}, al}, H / 8);
`else
  assign swp = '0;
`endif
  logic [2*W-1:0] p;
  logic [W-1:0] lo, hi, hp, res;
  logic cf;
  logic [5:0] fl;
  always_comb begin
    p = {pp11, pp00} + {{H{1'b0}}, pp01, {H{1'b0}}} + {{H{1'b0}}, pp10, {H{1'b0}}} - {corr, {W{1'b0}}};
    lo = p[W-1:0];
    hi = p[2*W-1:W];
    hp = op0 == 3'd5 ? pp00 - {hcorr, {H{1'b0}}} : pp00;
    res = ~op0[2] ? (op0[0] ? hi : lo) : ~op0[1] ? hp : swp;
    cf = op0 == 3'd0 ? |hi :
         op0 == 3'd2 ? hi != {W{lo[W-1]}} :
         op0 == 3'd4 ? |hp[W-1:H] :
         op0 == 3'd5 ? hp[W-1:H] != {H{hp[H-1]}} : 1'b0;
    fl = op0[2] & op0[1] ? 6'd0 : {cf, cf, 1'b0, res[W-1], ~|res, ~^res[7:0]};
  end
  logic dv [D];
  logic [TAG_W-1:0] dtag [D];
  logic [W-1:0] dres [D];
  logic [5:0] dflg [D];
  logic pv [D];
  logic [TAG_W-1:0] ptag [D];
  logic [W-1:0] pres [D];
  logic [5:0] pflg [D];
  always_comb begin
    pv[0] = v0;
    ptag[0] = tag0;
    pres[0] = res;
    pflg[0] = fl;
    for (int i = 1; i < D; i++) begin
      pv[i] = dv[i-1];
      ptag[i] = dtag[i-1];
      pres[i] = dres[i-1];
      pflg[i] = dflg[i-1];
    end
  end
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < D; i++) begin
        dv[i] <= 1'b0;
        dtag[i] <= '0;
        dres[i] <= '0;
        dflg[i] <= '0;
      end
    else if (io.clkEn)
      for (int i = 0; i < D; i++) begin
        dv[i] <= pv[i] & ~io.flush;
        dtag[i] <= ptag[i];
        dres[i] <= pres[i];
        dflg[i] <= pflg[i];
      end
  assign io.out_vld = dv[D-1];
  assign io.out_tag = dtag[D-1];
  assign io.Res = dres[D-1];
  assign io.flg = dflg[D-1];
endmodule

// File: tb/tb_imul_pipe.sv
// tb_imul_pipe: directed and randomized checks of imul_pipe against an arithmetic reference model
module tb_imul_pipe;
  logic clk = 1'b0;
  logic rst;
  int passed = 0;
  int total = 0;
  imul_pipe_if #(.WIDTH(64), .TAG_W(9)) io ();
  imul_pipe #(.WIDTH(64), .STAGES(3), .TAG_W(9)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;

  function automatic logic [69:0] ref_op(input logic [2:0] op, input logic [63:0] r, input logic [63:0] c);
    logic [127:0] pu, ps;
    logic signed [127:0] sr, sc;
    logic signed [63:0] hr, hc;
    logic [63:0] res;
    logic cf;
    pu = {64'd0, r} * {64'd0, c};
    sr = $signed({{64{r[63]}}, r});
    sc = $signed({{64{c[63]}}, c});
    ps = sr * sc;
    hr = $signed({{32{r[31]}}, r[31:0]});
    hc = $signed({{32{c[31]}}, c[31:0]});
    res = '0;
    cf = 1'b0;
    case (op)
      3'd0: begin res = pu[63:0]; cf = |pu[127:64]; end
      3'd1: res = pu[127:64];
      3'd2: begin res = ps[63:0]; cf = ps != {{64{res[63]}}, res}; end
      3'd3: res = ps[127:64];
      3'd4: begin res = {32'd0, r[31:0]} * {32'd0, c[31:0]}; cf = |res[63:32]; end
      3'd5: begin res = hr * hc; cf = res != {{32{res[31]}}, res[31:0]}; end
      default: begin
`ifdef IMUL_PIPE_SWP_EN
        for (int i = 0; i < 8; i++) if (op[0] || i < 4) res[8*i +: 8] = r[8*((op[0] ? 7 : 3) - i) +: 8];
`endif
        return {6'd0, res};
      end
    endcase
    return {cf, cf, 1'b0, res[63], res == 64'd0, ~^res[7:0], res};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [8:0] tag, input logic [63:0] r, input logic [63:0] c);
    io.in_en = 1'b1;
    io.in_op = op;
    io.in_tag = tag;
    io.R = r;
    io.C = c;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (io.out_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", io.out_vld); else passed++;
    total++; if (io.out_tag !== 9'd0) $display("FAIL reset_tag: got %h want 0", io.out_tag); else passed++;
    total++; if (io.Res !== 64'd0) $display("FAIL reset_res: got %h want 0", io.Res); else passed++;
    total++; if (io.flg !== 6'd0) $display("FAIL reset_flg: got %b want 0", io.flg); else passed++;
  endtask

  task automatic test_mul;
    issue(3'd0, 9'd1, 64'hFFFFFFFFFFFFFFFF, 64'd2);
    step();
    io.in_en = 1'b0;
    step();
    total++; if (io.out_vld !== 1'b0) $display("FAIL mul_early: got %b want 0", io.out_vld); else passed++;
    step();
    total++; if (io.out_vld !== 1'b1) $display("FAIL mul_vld: got %b want 1", io.out_vld); else passed++;
    total++; if (io.Res !== 64'hFFFFFFFFFFFFFFFE) $display("FAIL mul_res: got %h want fffffffffffffffe", io.Res); else passed++;
    total++; if (io.flg !== 6'b110100) $display("FAIL mul_flg: got %b want 110100", io.flg); else passed++;
    total++; if (io.out_tag !== 9'd1) $display("FAIL mul_tag: got %h want 1", io.out_tag); else passed++;
    step();
    total++; if (io.out_vld !== 1'b0) $display("FAIL mul_drop: got %b want 0", io.out_vld); else passed++;
  endtask

  task automatic test_back_to_back;
    issue(3'd2, 9'd5, 64'hFFFFFFFFFFFFFFFF, 64'd2);
    step();
    issue(3'd3, 9'd6, 64'hFFFFFFFFFFFFFFFF, 64'd2);
    step();
    io.in_en = 1'b0;
    step();
    total++; if (io.out_vld !== 1'b1 || io.out_tag !== 9'd5) $display("FAIL b2b_first: got vld %b tag %h want 1 5", io.out_vld, io.out_tag); else passed++;
    total++; if (io.Res !== 64'hFFFFFFFFFFFFFFFE) $display("FAIL imul_res: got %h want fffffffffffffffe", io.Res); else passed++;
    total++; if (io.flg !== 6'b000100) $display("FAIL imul_flg: got %b want 000100", io.flg); else passed++;
    step();
    total++; if (io.out_vld !== 1'b1 || io.out_tag !== 9'd6) $display("FAIL b2b_second: got vld %b tag %h want 1 6", io.out_vld, io.out_tag); else passed++;
    total++; if (io.Res !== 64'hFFFFFFFFFFFFFFFF) $display("FAIL limul_res: got %h want ffffffffffffffff", io.Res); else passed++;
    total++; if (io.flg !== 6'b000101) $display("FAIL limul_flg: got %b want 000101", io.flg); else passed++;
    step();
    total++; if (io.out_vld !== 1'b0) $display("FAIL b2b_drop: got %b want 0", io.out_vld); else passed++;
  endtask

  task automatic test_half;
    issue(3'd4, 9'd9, 64'hDEADBEEF00010000, 64'h10000);
    step();
    io.in_en = 1'b0;
    step();
    step();
    total++; if (io.out_vld !== 1'b1) $display("FAIL mulh_vld: got %b want 1", io.out_vld); else passed++;
    total++; if (io.Res !== 64'h0000000100000000) $display("FAIL mulh_res: got %h want 0000000100000000", io.Res); else passed++;
    total++; if (io.flg !== 6'b110001) $display("FAIL mulh_flg: got %b want 110001", io.flg); else passed++;
    step();
  endtask

  task automatic test_stall;
    issue(3'd0, 9'd7, 64'd3, 64'd5);
    step();
    io.in_en = 1'b0;
    io.clkEn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (io.out_vld !== 1'b0) $display("FAIL stall_hold_empty: got %b want 0", io.out_vld); else passed++;
    end
    io.clkEn = 1'b1;
    step();
    total++; if (io.out_vld !== 1'b0) $display("FAIL stall_early: got %b want 0", io.out_vld); else passed++;
    step();
    total++; if (io.out_vld !== 1'b1 || io.Res !== 64'd15) $display("FAIL stall_result: got vld %b res %h want 1 f", io.out_vld, io.Res); else passed++;
    io.clkEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (io.out_vld !== 1'b1 || io.Res !== 64'd15 || io.out_tag !== 9'd7) $display("FAIL stall_out_hold: got vld %b res %h tag %h want 1 f 7", io.out_vld, io.Res, io.out_tag); else passed++;
    end
    io.clkEn = 1'b1;
    step();
    total++; if (io.out_vld !== 1'b0) $display("FAIL stall_drop: got %b want 0", io.out_vld); else passed++;
  endtask

  task automatic test_flush;
    issue(3'd0, 9'd1, 64'd1, 64'd1);
    step();
    issue(3'd0, 9'd2, 64'd2, 64'd2);
    step();
    issue(3'd0, 9'd3, 64'd3, 64'd3);
    io.flush = 1'b1;
    step();
    io.flush = 1'b0;
    total++; if (io.out_vld !== 1'b0) $display("FAIL flush_kill0: got %b want 0", io.out_vld); else passed++;
    issue(3'd0, 9'd4, 64'd6, 64'd7);
    step();
    io.in_en = 1'b0;
    total++; if (io.out_vld !== 1'b0) $display("FAIL flush_kill1: got %b want 0", io.out_vld); else passed++;
    step();
    total++; if (io.out_vld !== 1'b0) $display("FAIL flush_kill2: got %b want 0", io.out_vld); else passed++;
    step();
    total++; if (io.out_vld !== 1'b1 || io.out_tag !== 9'd4 || io.Res !== 64'd42) $display("FAIL flush_after: got vld %b tag %h res %h want 1 4 2a", io.out_vld, io.out_tag, io.Res); else passed++;
    issue(3'd0, 9'd8, 64'd2, 64'd2);
    step();
    io.in_en = 1'b0;
    io.clkEn = 1'b0;
    io.flush = 1'b1;
    step();
    io.flush = 1'b0;
    io.clkEn = 1'b1;
    step();
    total++; if (io.out_vld !== 1'b0) $display("FAIL flush_stall_early: got %b want 0", io.out_vld); else passed++;
    step();
    total++; if (io.out_vld !== 1'b1 || io.out_tag !== 9'd8 || io.Res !== 64'd4) $display("FAIL flush_stall_ignored: got vld %b tag %h res %h want 1 8 4", io.out_vld, io.out_tag, io.Res); else passed++;
    step();
  endtask

  task automatic test_reset_midflight;
    issue(3'd0, 9'd10, 64'd9, 64'd9);
    step();
    issue(3'd2, 9'd11, 64'd5, 64'd5);
    step();
    io.in_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (io.out_vld !== 1'b0 || io.Res !== 64'd0 || io.flg !== 6'd0) $display("FAIL midrst_out: got vld %b res %h flg %b want 0 0 0", io.out_vld, io.Res, io.flg); else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (io.out_vld !== 1'b0) $display("FAIL midrst_lost: got %b want 0", io.out_vld); else passed++;
    end
  endtask

  task automatic test_swp;
    logic [63:0] e7, e6;
`ifdef IMUL_PIPE_SWP_EN
    e7 = 64'h0807060504030201;
    e6 = 64'h0000000008070605;
`else
    e7 = 64'd0;
    e6 = 64'd0;
`endif
    issue(3'd7, 9'd12, 64'h0102030405060708, 64'd5);
    step();
    issue(3'd6, 9'd13, 64'h0102030405060708, 64'd5);
    step();
    io.in_en = 1'b0;
    step();
    total++; if (io.out_vld !== 1'b1 || io.out_tag !== 9'd12) $display("FAIL swp_vld: got vld %b tag %h want 1 c", io.out_vld, io.out_tag); else passed++;
    total++; if (io.Res !== e7 || io.flg !== 6'd0) $display("FAIL swp_res: got %h flg %b want %h 0", io.Res, io.flg, e7); else passed++;
    step();
    total++; if (io.out_vld !== 1'b1 || io.out_tag !== 9'd13) $display("FAIL swph_vld: got vld %b tag %h want 1 d", io.out_vld, io.out_tag); else passed++;
    total++; if (io.Res !== e6 || io.flg !== 6'd0) $display("FAIL swph_res: got %h flg %b want %h 0", io.Res, io.flg, e6); else passed++;
    step();
  endtask

  task automatic test_random;
    logic rv [0:1023];
    logic [8:0] rt [0:1023];
    logic [69:0] rx [0:1023];
    logic ce, en, fl, ev;
    logic [2:0] op;
    logic [8:0] tag, et;
    logic [63:0] r, c;
    logic [69:0] ex;
    int adv;
    for (int i = 0; i < 1024; i++) rv[i] = 1'b0;
    adv = 2;
    ev = 1'b0;
    et = '0;
    ex = '0;
    for (int n = 0; n < 400; n++) begin
      ce = $urandom_range(0, 9) < 8;
      en = $urandom_range(0, 1) == 1;
      fl = $urandom_range(0, 19) == 0;
      op = 3'($urandom_range(0, 7));
      tag = 9'($urandom);
      r = $urandom_range(0, 3) == 0 ? 64'hFFFFFFFFFFFFFFFF : {$urandom, $urandom};
      c = $urandom_range(0, 3) == 0 ? 64'd0 : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) c = {{32{c[31]}}, c[31:0]};
      io.clkEn = ce;
      io.flush = fl;
      io.in_en = en;
      io.in_op = op;
      io.in_tag = tag;
      io.R = r;
      io.C = c;
      step();
      if (ce) begin
        adv++;
        rv[adv] = en & ~fl;
        rt[adv] = tag;
        rx[adv] = ref_op(op, r, c);
        if (fl) begin
          rv[adv-1] = 1'b0;
          rv[adv-2] = 1'b0;
        end
        ev = rv[adv-2];
        et = rt[adv-2];
        ex = rx[adv-2];
      end
      total++; if (io.out_vld !== ev) $display("FAIL rand_vld n=%0d: got %b want %b", n, io.out_vld, ev); else passed++;
      if (ev) begin
        total++; if (io.out_tag !== et) $display("FAIL rand_tag n=%0d: got %h want %h", n, io.out_tag, et); else passed++;
        total++; if (io.Res !== ex[63:0]) $display("FAIL rand_res n=%0d: got %h want %h", n, io.Res, ex[63:0]); else passed++;
        total++; if (io.flg !== ex[69:64]) $display("FAIL rand_flg n=%0d: got %b want %b", n, io.flg, ex[69:64]); else passed++;
      end
    end
    io.clkEn = 1'b1;
    io.flush = 1'b0;
    io.in_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    io.clkEn = 1'b1;
    io.flush = 1'b0;
    io.in_en = 1'b0;
    io.in_op = '0;
    io.in_tag = '0;
    io.R = '0;
    io.C = '0;
    test_reset();
    test_mul();
    test_back_to_back();
    test_half();
    test_stall();
    test_flush();
    test_reset_midflight();
    test_swp();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
